simplerisc_imem_loader: RTL and testbench
=========================================

Name: simplerisc_imem_loader

Overview:
- Upstream feeder for the single-cycle SimpleRISC core.
- Accepts a program as a stream of 32-bit instruction words over a valid/ready handshake.
- Packs the words into the flat 8192-bit instruction-memory image the core fetches from.
- Holds the core in reset while loading, and for a programmable number of cycles afterwards, then releases it to run.

Parameters:
- NUM_WORDS, 256: instruction words in the image. The image width is NUM_WORDS*32, which is 8192 at the default.
- RESET_HOLD, 4: cycles `cpu_reset` stays high after the last word is accepted. Range 1..255.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset; the block is in reset while low.
- start  in  1  one-cycle request to begin a (re)load. Sampled only in IDLE and RUN.
- wr_valid  in  1  producer has a word on `wr_data`.
- wr_data  in  32  instruction word.
- wr_last  in  1  qualifies `wr_data` as the final word of the program.
- wr_ready  out  1  loader can accept a word this cycle.
- imem_image  out  [0:8191]  packed program, driven to the core's instruction-memory input.
- cpu_reset  out  1  active-high reset to the core.
- loaded  out  1  high in RUN only.
- word_count  out  9  words accepted in the current load (0..256).
- truncated  out  1  sticky: NUM_WORDS words were accepted without `wr_last`.

Behaviour:
- All outputs are registered.
- Reset (`reset` low): asynchronous clear to the following values.
  - state = IDLE
  - `imem_image` = all zero
  - `cpu_reset` = 1
  - `wr_ready` = 0, `loaded` = 0, `word_count` = 0, `truncated` = 0, hold counter = 0
- Packing: word i occupies `imem_image[32*i : 32*i+31]`. Index 32*i is the MSB (bit 31) of word i, so word 0 sits at indices 0..31.
- States: IDLE, LOAD, HOLD, RUN.
- IDLE
  - `cpu_reset` = 1, `wr_ready` = 0.
  - `start` = 1: next state LOAD; `word_count`, `truncated` and the whole image clear to 0.
- LOAD
  - `wr_ready` = 1.
  - A transfer occurs when `wr_valid` and `wr_ready` are both high at a rising edge. On a transfer:
    - `wr_data` is written to word index `word_count`.
    - `word_count` increments.
    - The written word is visible on `imem_image` after that same edge.
  - Transfer with `wr_last` = 1: next state HOLD; `wr_ready` drops on the next cycle.
  - Transfer of word NUM_WORDS-1 with `wr_last` = 0: next state HOLD and `truncated` sets to 1. The stream is not drained; further `wr_valid` is simply not accepted.
  - `wr_valid` = 0: no change; stalls of any length are allowed.
  - `start` is ignored.
- HOLD
  - `wr_ready` = 0, `cpu_reset` = 1.
  - The hold counter counts 1..RESET_HOLD.
  - Next state RUN on the edge where the count equals RESET_HOLD.
  - `start` is ignored.
- RUN
  - `cpu_reset` = 0, `loaded` = 1, image is static.
  - `start` = 1 is a reload, taking effect at the next edge:
    - next state LOAD
    - `cpu_reset` = 1
    - `loaded` = 0
    - image, `word_count` and `truncated` clear
- Timing: `cpu_reset` falls exactly RESET_HOLD+1 edges after the edge accepting the final word. It rises exactly one edge after `start` is sampled in RUN.
- Word data is not interpreted; opcodes are the core's concern.
- `reset` asserted mid-LOAD: the partial image is discarded (cleared) and the state returns to IDLE. Loading does not resume after `reset` deasserts until `start` is given.
- `wr_last` with `wr_valid` = 0 has no effect.

Test Plan:
- Reset then idle: `reset` low 3 cycles, release, no `start` -> `cpu_reset` = 1, `wr_ready` = 0, `imem_image` = 0, `loaded` = 0 indefinitely.
- Short program: `start`, then 3 back-to-back words 0x4E000005, 0x4E400003, 0x00084000, with `wr_last` on the third ->
  - `word_count` = 3
  - `imem_image[0:31]` = 0x4E000005, `[32:63]` = 0x4E400003, `[64:95]` = 0x00084000, `[96:8191]` = 0
  - `cpu_reset` falls 5 edges after the third accept (RESET_HOLD = 4)
  - `truncated` = 0
- Stalled stream: 4 words with `wr_valid` gaps of 0, 2 and 7 cycles -> each word lands at indices 0..3 in order, no duplicates, `word_count` = 4.
- Overflow: 300 words, never `wr_last`; word i = i ->
  - `word_count` = 256, `truncated` = 1
  - word 255 = 0x000000FF
  - `wr_ready` stays 0 after the 256th accept; words 256+ are ignored
- Reload from RUN: after the short-program run, `start`, then 1 word 0xFFFFFFFF with `wr_last` ->
  - `cpu_reset` rises one edge after `start`
  - old words 1..2 read back as 0
  - word 0 = 0xFFFFFFFF
  - `loaded` returns to 1 after the hold
- Reset mid-load: `start`, accept 2 words, assert `reset` low ->
  - image cleared immediately (asynchronously), state IDLE, `word_count` = 0, `cpu_reset` = 1
  - `wr_valid` after release is not accepted until `start`

Source files
------------

// File: rtl/simplerisc_imem_loader.sv
// ============================================================================
// Module   : simplerisc_imem_loader
// Brief    : Streams 32-bit words into the SimpleRISC instruction image and
//            sequences the core's reset around each (re)load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simplerisc_imem_loader #(
    parameter int NUM_WORDS  = 256,
    parameter int RESET_HOLD = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             wr_valid,
    input  logic [31:0]                      wr_data,
    input  logic                             wr_last,
    output logic                             wr_ready,
    output logic [0:NUM_WORDS*32-1]          imem_image,
    output logic                             cpu_reset,
    output logic                             loaded,
    output logic [$clog2(NUM_WORDS+1)-1:0]   word_count,
    output logic                             truncated
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int IDX_W = $clog2(NUM_WORDS * 32);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;
    localparam logic [1:0] c_run  = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NUM_WORDS - 1);
    localparam logic [7:0]       c_hold_end = 8'(RESET_HOLD);

    logic [1:0]       state;
    logic [7:0]       hold_cnt;
    logic             xfer;
    logic             last_slot;
    logic [IDX_W-1:0] wr_base;

    assign xfer      = wr_valid && wr_ready;
    assign last_slot = (word_count == c_cnt_last);
    // Word i starts at bit index 32*i; index 32*i is the word's MSB.
    assign wr_base   = {word_count[IDX_W-6:0], 5'b0_0000};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= c_idle;
            imem_image <= '0;
            cpu_reset  <= 1'b1;
            wr_ready   <= 1'b0;
            loaded     <= 1'b0;
            word_count <= '0;
            truncated  <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                c_idle: begin
                    if (start) begin
                        state      <= c_load;
                        wr_ready   <= 1'b1;
                        imem_image <= '0;
                        word_count <= '0;
                        truncated  <= 1'b0;
                    end
                end
                c_load: begin
                    if (xfer) begin
                        imem_image[wr_base +: 32] <= wr_data;
                        word_count <= word_count + c_cnt_one;
                        // A full image without wr_last ends the load; the
                        // producer's remaining words are left unaccepted.
                        if (wr_last || last_slot) begin
                            state     <= c_hold;
                            wr_ready  <= 1'b0;
                            hold_cnt  <= '0;
                            truncated <= ~wr_last;
                        end
                    end
                end
                c_hold: begin
                    if (hold_cnt == c_hold_end) begin
                        state     <= c_run;
                        cpu_reset <= 1'b0;
                        loaded    <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                c_run: begin
                    if (start) begin
                        state      <= c_load;
                        cpu_reset  <= 1'b1;
                        loaded     <= 1'b0;
                        wr_ready   <= 1'b1;
                        imem_image <= '0;
                        word_count <= '0;
                        truncated  <= 1'b0;
                    end
                end
                default: begin
                    state <= c_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simplerisc_imem_loader.sv
// ============================================================================
// Module   : tb_simplerisc_imem_loader
// Brief    : Self-checking bench for simplerisc_imem_loader against a
//            word-array model of the expected image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simplerisc_imem_loader;

    localparam int NW = 256;
    localparam int RH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              wr_valid;
    logic [31:0]       wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic [0:NW*32-1]  imem_image;
    logic              cpu_reset;
    logic              loaded;
    logic [8:0]        word_count;
    logic              truncated;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_img [NW];
    int          exp_count;

    simplerisc_imem_loader #(.NUM_WORDS(NW), .RESET_HOLD(RH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .imem_image (imem_image),
        .cpu_reset  (cpu_reset),
        .loaded     (loaded),
        .word_count (word_count),
        .truncated  (truncated)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dut_word(input int i);
        return imem_image[32*i +: 32];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NW; i++) exp_img[i] = 32'h0;
        exp_count = 0;
    endtask

    function automatic int image_bad(output int first);
        int bad = 0;
        first = -1;
        for (int i = 0; i < NW; i++) begin
            if (dut_word(i) !== exp_img[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic last, input int gap, output logic ok);
        wr_valid = 1'b0;
        repeat (gap) tick();
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (ok) begin
            exp_img[exp_count] = d;
            exp_count++;
        end
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (cpu_reset && n < 600) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        int first;
        reset = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        model_clear();
        repeat (3) tick();
        checks++;
        if ({cpu_reset, wr_ready, loaded, truncated} !== 4'b1000 || word_count !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs: got cpu_reset=%b wr_ready=%b loaded=%b trunc=%b count=%0d, want 1 0 0 0 0",
                     cpu_reset, wr_ready, loaded, truncated, word_count);
        end
        checks++;
        if (image_bad(first) !== 0) begin
            failures++;
            $display("FAIL reset_image: word %0d = %h, want 0", first, dut_word(first));
        end
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (cpu_reset !== 1'b1 || wr_ready !== 1'b0 || loaded !== 1'b0 || imem_image !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_hold: %0d idle cycles deviated, want 0", bad);
        end
    endtask

    task automatic test_short_program();
        logic ok0, ok1, ok2;
        int n, first;
        model_clear();
        do_start();
        push(32'h4E000005, 1'b0, 0, ok0);
        push(32'h4E400003, 1'b0, 0, ok1);
        push(32'h00084000, 1'b1, 0, ok2);
        checks++;
        if ({ok0, ok1, ok2} !== 3'b111) begin
            failures++;
            $display("FAIL short_accept: accepted=%b, want 111", {ok0, ok1, ok2});
        end
        checks++;
        if (word_count !== 9'd3 || wr_ready !== 1'b0 || cpu_reset !== 1'b1 || truncated !== 1'b0) begin
            failures++;
            $display("FAIL short_after_last: count=%0d ready=%b cpu_reset=%b trunc=%b, want 3 0 1 0",
                     word_count, wr_ready, cpu_reset, truncated);
        end
        wait_release(n);
        checks++;
        if (n !== RH + 1) begin
            failures++;
            $display("FAIL short_release_edges: got %0d, want %0d", n, RH + 1);
        end
        checks++;
        if (loaded !== 1'b1 || dut_word(0) !== 32'h4E000005 || dut_word(1) !== 32'h4E400003
            || dut_word(2) !== 32'h00084000) begin
            failures++;
            $display("FAIL short_words: loaded=%b w0=%h w1=%h w2=%h, want 1 4e000005 4e400003 00084000",
                     loaded, dut_word(0), dut_word(1), dut_word(2));
        end
        checks++;
        if (image_bad(first) !== 0) begin
            failures++;
            $display("FAIL short_image: word %0d = %h, want %h", first, dut_word(first), exp_img[first]);
        end
    endtask

    task automatic test_reload();
        logic ok;
        int n, first;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1 || loaded !== 1'b0 || wr_ready !== 1'b1 || word_count !== 9'd0) begin
            failures++;
            $display("FAIL reload_enter: cpu_reset=%b loaded=%b ready=%b count=%0d, want 1 0 1 0",
                     cpu_reset, loaded, wr_ready, word_count);
        end
        checks++;
        if (dut_word(1) !== 32'h0 || dut_word(2) !== 32'h0) begin
            failures++;
            $display("FAIL reload_clear: w1=%h w2=%h, want 0 0", dut_word(1), dut_word(2));
        end
        model_clear();
        push(32'hFFFFFFFF, 1'b1, 0, ok);
        wait_release(n);
        checks++;
        if (!ok || n !== RH + 1 || loaded !== 1'b1 || dut_word(0) !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL reload_run: ok=%b edges=%0d loaded=%b w0=%h, want 1 %0d 1 ffffffff",
                     ok, n, loaded, dut_word(0), RH + 1);
        end
        checks++;
        if (image_bad(first) !== 0) begin
            failures++;
            $display("FAIL reload_image: word %0d = %h, want %h", first, dut_word(first), exp_img[first]);
        end
    endtask

    task automatic test_stalled();
        int gaps[4] = '{0, 2, 7, 3};
        logic [31:0] d;
        logic ok, all_ok;
        int n, first;
        model_clear();
        do_start();
        all_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            push(d, (k == 3), gaps[k], ok);
            all_ok &= ok;
        end
        wait_release(n);
        checks++;
        if (!all_ok || word_count !== 9'd4 || n !== RH + 1) begin
            failures++;
            $display("FAIL stalled_count: ok=%b count=%0d edges=%0d, want 1 4 %0d", all_ok, word_count, n, RH + 1);
        end
        checks++;
        if (image_bad(first) !== 0) begin
            failures++;
            $display("FAIL stalled_image: word %0d = %h, want %h", first, dut_word(first), exp_img[first]);
        end
    endtask

    task automatic test_random_programs();
        logic ok, all_ok;
        int len, n, first;
        for (int it = 0; it < 3; it++) begin
            model_clear();
            do_start();
            len = $urandom_range(1, 24);
            all_ok = 1'b1;
            for (int k = 0; k < len; k++) begin
                push($urandom, (k == len - 1), $urandom_range(0, 3), ok);
                all_ok &= ok;
            end
            wait_release(n);
            checks++;
            if (!all_ok || word_count !== 9'(len) || truncated !== 1'b0 || n !== RH + 1) begin
                failures++;
                $display("FAIL random_prog%0d: ok=%b count=%0d trunc=%b edges=%0d, want 1 %0d 0 %0d",
                         it, all_ok, word_count, truncated, n, len, RH + 1);
            end
            checks++;
            if (image_bad(first) !== 0) begin
                failures++;
                $display("FAIL random_image%0d: word %0d = %h, want %h",
                         it, first, dut_word(first), exp_img[first]);
            end
        end
    endtask

    task automatic test_overflow();
        int idx = 0;
        int first;
        logic acc;
        logic ready_late = 1'b0;
        model_clear();
        for (int i = 0; i < NW; i++) exp_img[i] = 32'(i);
        do_start();
        for (int c = 0; c < 400; c++) begin
            wr_valid = 1'b1;
            wr_last  = 1'b0;
            wr_data  = 32'(idx);
            acc = wr_ready;
            if (idx >= NW && wr_ready) ready_late = 1'b1;
            tick();
            if (acc) idx++;
        end
        wr_valid = 1'b0;
        checks++;
        if (idx !== NW || word_count !== 9'd256 || truncated !== 1'b1 || ready_late !== 1'b0) begin
            failures++;
            $display("FAIL overflow_count: accepted=%0d count=%0d trunc=%b late_ready=%b, want 256 256 1 0",
                     idx, word_count, truncated, ready_late);
        end
        checks++;
        if (dut_word(255) !== 32'h000000FF || loaded !== 1'b1) begin
            failures++;
            $display("FAIL overflow_last: w255=%h loaded=%b, want 000000ff 1", dut_word(255), loaded);
        end
        checks++;
        if (image_bad(first) !== 0) begin
            failures++;
            $display("FAIL overflow_image: word %0d = %h, want %h", first, dut_word(first), exp_img[first]);
        end
    endtask

    task automatic test_reset_mid_load();
        logic ok0, ok1, ok;
        logic ready_seen = 1'b0;
        int n, first;
        model_clear();
        do_start();
        push($urandom, 1'b0, 0, ok0);
        push($urandom, 1'b0, 1, ok1);
        checks++;
        if ({ok0, ok1} !== 2'b11 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL midload_pre: accepted=%b count=%0d, want 11 2", {ok0, ok1}, word_count);
        end
        #2 reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if (image_bad(first) !== 0) begin
            failures++;
            $display("FAIL midload_image: word %0d = %h, want 0", first, dut_word(first));
        end
        checks++;
        if (word_count !== 9'd0 || cpu_reset !== 1'b1 || wr_ready !== 1'b0 || loaded !== 1'b0) begin
            failures++;
            $display("FAIL midload_state: count=%0d cpu_reset=%b ready=%b loaded=%b, want 0 1 0 0",
                     word_count, cpu_reset, wr_ready, loaded);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            wr_valid = 1'b1;
            wr_data  = $urandom;
            if (wr_ready) ready_seen = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (ready_seen !== 1'b0 || word_count !== 9'd0) begin
            failures++;
            $display("FAIL midload_no_resume: ready_seen=%b count=%0d, want 0 0", ready_seen, word_count);
        end
        do_start();
        push(32'hA5A5_0F0F, 1'b1, 0, ok);
        wait_release(n);
        checks++;
        if (!ok || n !== RH + 1 || image_bad(first) !== 0) begin
            failures++;
            $display("FAIL midload_restart: ok=%b edges=%0d bad_word=%0d, want 1 %0d -1", ok, n, first, RH + 1);
        end
    endtask

    initial begin
        test_reset();
        test_short_program();
        test_reload();
        test_stalled();
        test_random_programs();
        test_overflow();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
